lsu_data_port: RTL and testbench

//  Parametrised data-side load/store port for the RV32 core: takes one load/store request at a time

---
 rtl/lsu_data_port.sv | 150 +++++++++++++++
 tb/tb_lsu_data_port.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_data_port.sv
// lsu_data_port: single-outstanding load/store port driving one Wishbone classic cycle per request
module lsu_data_port #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_misaligned,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    output logic [3:0]        wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);
    typedef enum logic {IDLE, BUS} state_t;
    localparam int CW = $clog2(TIMEOUT);
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cyc_q, cyc_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       dat_q, dat_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              mis_q, mis_d;
    logic              to_q, to_d;
    logic              mis;
    logic [31:0]       lane, ld;
    assign req_ready      = state_q == IDLE;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rdata_q;
    assign rsp_err        = err_q;
    assign rsp_misaligned = mis_q;
    assign rsp_timeout    = to_q;
    assign wb_adr_o       = adr_q;
    assign wb_dat_o       = dat_q;
    assign wb_sel_o       = sel_q;
    assign wb_we_o        = we_q;
    assign wb_cyc_o       = cyc_q;
    assign wb_stb_o       = cyc_q;
    assign mis  = (req_size == 2'b01 & req_addr[0]) | (req_size[1] & |req_addr[1:0]);
    assign lane = wb_dat_i >> {off_q, 3'b000};
    assign ld   = size_q == 2'b00 ? {{24{~uns_q & lane[7]}}, lane[7:0]} :
                  size_q == 2'b01 ? {{16{~uns_q & lane[15]}}, lane[15:0]} : lane;
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mis_d       = mis_q;
        to_d        = to_q;
        if (state_q == IDLE && req_valid) begin
            if (mis) begin
                rsp_valid_d = 1'b1;
                rdata_d     = '0;
                err_d       = 1'b0;
                mis_d       = 1'b1;
                to_d        = 1'b0;
            end else begin
                state_d = BUS;
                cnt_d   = '0;
                cyc_d   = 1'b1;
                adr_d   = {req_addr[ADDR_W-1:2], 2'b00};
                sel_d   = req_size == 2'b00 ? 4'b0001 << req_addr[1:0] :
                          req_size == 2'b01 ? 4'b0011 << req_addr[1:0] : 4'hF;
                dat_d   = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                          req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
                we_d    = req_we;
                size_d  = req_size;
                uns_d   = req_unsigned;
                off_d   = req_addr[1:0];
            end
        end else if (state_q == BUS) begin
            cnt_d = cnt_q + 1'b1;
            if (wb_ack_i | wb_err_i | cnt_q == CW'(TIMEOUT - 1)) begin
                state_d     = IDLE;
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b1;
                err_d       = wb_err_i;
                mis_d       = 1'b0;
                to_d        = ~(wb_ack_i | wb_err_i);
                rdata_d     = (wb_ack_i & ~wb_err_i & ~we_q) ? ld : '0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            dat_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            off_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            mis_q       <= 1'b0;
            to_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            mis_q       <= mis_d;
            to_q        <= to_d;
        end
    end
endmodule

// File: tb/tb_lsu_data_port.sv
// tb_lsu_data_port: random load/store traffic against a byte-level reference model with a queue scoreboard
module tb_lsu_data_port;
    localparam int TO = 8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        rsp_valid, rsp_err, rsp_misaligned, rsp_timeout;
    logic [31:0] rsp_rdata, wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;

    lsu_data_port #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_misaligned(rsp_misaligned), .rsp_timeout(rsp_timeout),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] rdata; logic err; logic mis; logic to;} rsp_t;
    typedef struct packed {logic [31:0] adr; logic [3:0] sel; logic [31:0] dat; logic we;} bus_t;
    rsp_t rq[$];
    bus_t bq[$];
    int   lq[$];
    int   checks = 0, failures = 0;
    int   s_kind = 3, s_wait = 0, s_cnt = 0;
    logic idle_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Slave: kind 0=ack 1=err 2=ack+err 3=silent, answering after s_wait wait states
    initial forever begin
        @(negedge clk);
        if (wb_cyc_o) begin
            wb_ack_i = (s_kind == 0 || s_kind == 2) && s_cnt == s_wait;
            wb_err_i = (s_kind == 1 || s_kind == 2) && s_cnt == s_wait;
            s_cnt++;
        end else begin
            wb_ack_i = idle_ack;
            wb_err_i = idle_ack;
            s_cnt = 0;
        end
    end

    initial begin
        rsp_t r;
        bus_t b;
        logic pc;
        int   len;
        pc = 1'b0;
        len = 0;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (rq.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
                else begin
                    r = rq.pop_front();
                    chk("rsp_rdata", rsp_rdata, r.rdata);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
                    chk("rsp_misaligned", {31'd0, rsp_misaligned}, {31'd0, r.mis});
                    chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, r.to});
                end
            end
            if (wb_cyc_o && !pc) begin
                len = 0;
                if (bq.size() == 0) chk("unexpected_cyc", 32'd1, 32'd0);
                else begin
                    b = bq.pop_front();
                    chk("wb_adr", wb_adr_o, b.adr);
                    chk("wb_sel", {28'd0, wb_sel_o}, {28'd0, b.sel});
                    chk("wb_dat", wb_dat_o, b.dat);
                    chk("wb_we", {31'd0, wb_we_o}, {31'd0, b.we});
                    chk("wb_stb", {31'd0, wb_stb_o}, 32'd1);
                end
            end
            if (wb_cyc_o) len++;
            if (!wb_cyc_o && pc) begin
                if (lq.size() == 0) chk("unexpected_cyc_end", 32'd1, 32'd0);
                else chk("cyc_len", len, lq.pop_front());
            end
            pc = wb_cyc_o;
        end
    end

    task automatic do_txn(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] bus, input int kind, input int wt);
        int nb, off, lat, n;
        logic [31:0] v;
        bus_t b;
        rsp_t r;
        logic m;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(addr % 4);
        m = (addr % nb) != 0;
        b.adr = addr & 32'hFFFF_FFFC;
        b.we = we;
        b.sel = '0;
        b.dat = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nb) b.sel[i] = 1'b1;
            b.dat[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        v = '0;
        if (!m) for (int k = 0; k < nb; k++) v[8*k +: 8] = bus[8*(off+k) +: 8];
        if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        r = '0;
        if (m) begin
            r.mis = 1'b1;
            lat = 1;
        end else if (kind == 3) begin
            r.to = 1'b1;
            lat = TO + 1;
        end else begin
            r.err = kind != 0;
            r.rdata = (r.err || we) ? 32'd0 : v;
            lat = wt + 2;
        end
        if (!m) begin
            bq.push_back(b);
            lq.push_back(kind == 3 ? TO : wt + 1);
        end
        rq.push_back(r);
        s_kind = kind;
        s_wait = wt;
        wb_dat_i = bus;
        req_we = we;
        req_size = sz;
        req_unsigned = uns;
        req_addr = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < TO + 6);
        chk("latency", n, lat);
        chk("req_ready_rsp", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("rst_flags", {29'd0, rsp_err, rsp_misaligned, rsp_timeout}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        rst = 1'b0;
        idle_ack = 1'b1;
        repeat (3) @(negedge clk);
        idle_ack = 1'b0;
        @(negedge clk);
        do_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 32'h80FF1234, 0, 0);
        do_txn(1'b0, 2'd1, 1'b1, 32'h102, 32'd0, 32'hBEEF0000, 0, 1);
        do_txn(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, $urandom, 0, 2);
        do_txn(1'b0, 2'd2, 1'b0, 32'h301, 32'd0, 32'd0, 0, 0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h400, 32'd0, 32'h12345678, 3, 0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h500, 32'd0, 32'hDEADBEEF, 2, 0);
        do_txn(1'b0, 2'd0, 1'b1, 32'h7, 32'd0, 32'hCAFEF00D, 1, 3);
        do_txn(1'b0, 2'd3, 1'b0, 32'h600, 32'd0, 32'h0BADF00D, 0, TO - 1);
        for (int i = 0; i < 300; i++) begin
            k = int'($urandom % 6);
            do_txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                   k < 3 ? 0 : k - 2, int'($urandom % TO));
            repeat ($urandom % 3) @(negedge clk);
        end
        s_kind = 3;
        bq.push_back('{adr: 32'h800, sel: 4'hF, dat: 32'h11223344, we: 1'b0});
        lq.push_back(2);
        req_we = 1'b0;
        req_size = 2'd2;
        req_addr = 32'h800;
        req_wdata = 32'h11223344;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_bus_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_bus_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("rst_bus_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("rst_bus_ready", {31'd0, req_ready}, 32'd1);
        repeat (TO + 3) @(negedge clk);
        chk("rsp_queue_empty", rq.size(), 32'd0);
        chk("bus_queue_empty", bq.size(), 32'd0);
        chk("len_queue_empty", lq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
